// File: rtl/mc_pkg.sv
// Shared types and defaults for the MC_32 matrix calculator datapath:
// collector state enum, default sizes and a row-packing helper.
package mc_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int N_DEF      = 4;
    localparam int PE_LAT_DEF = 4;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } collector_state_t;

    // Packs N_DEF elements into one row, element 0 in the MSBs.
    function automatic logic [N_DEF*DATA_W_DEF-1:0] pack_row(
        input logic [DATA_W_DEF-1:0] elems [N_DEF]
    );
        logic [N_DEF*DATA_W_DEF-1:0] row;
        row = '0;
        for (int i = 0; i < N_DEF; i++) begin
            row[(N_DEF-1-i)*DATA_W_DEF +: DATA_W_DEF] = elems[i];
        end
        return row;
    endfunction

endpackage

// File: rtl/pe_valid_tracker.sv
// Counts consecutive enable-high cycles (saturating at PE_LAT) and flags the
// edges on which the PE pipeline output is valid.
module pe_valid_tracker #(
    parameter int PE_LAT = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic en,
    output logic sample
);

    localparam int CNT_W = $clog2(PE_LAT + 1);

    logic [CNT_W-1:0] run_cnt_reg;
    logic [CNT_W-1:0] run_cnt_next;

    always_comb begin
        run_cnt_next = run_cnt_reg;
        if (!en) begin
            run_cnt_next = '0;
        end else if (run_cnt_reg != CNT_W'(PE_LAT)) begin
            run_cnt_next = run_cnt_reg + 1'b1;
        end
    end

    // The edge completing the PE_LAT-th consecutive high cycle already captures,
    // so the comparison looks at the count including the current cycle.
    assign sample = en && (run_cnt_next == CNT_W'(PE_LAT));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            run_cnt_reg <= '0;
        end else begin
            run_cnt_reg <= run_cnt_next;
        end
    end

endmodule

// File: rtl/pe_result_collector.sv
// Captures the PE result stream into an N*N row-major buffer, then drains it one
// packed row per handshake. Optional drop counter: MC_COLLECT_DROPCNT_EN.
module pe_result_collector
    import mc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N      = N_DEF,
    parameter int PE_LAT = PE_LAT_DEF
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  pe_en,
    input  logic [DATA_W-1:0]     pe_c,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*DATA_W-1:0]   out_row,
    output logic [$clog2(N)-1:0]  out_row_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  ovf
`ifdef MC_COLLECT_DROPCNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    localparam int PTR_W = $clog2(N * N);
    localparam int ROW_W = $clog2(N);

    collector_state_t   state_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [ROW_W-1:0]   rd_row_reg;
    logic               ovf_reg;
    logic [DATA_W-1:0]  mem_reg [N*N];
    logic [N*DATA_W-1:0] row_packed;
    logic               sample;
    logic               capture;
    logic               drop;

    pe_valid_tracker #(
        .PE_LAT (PE_LAT)
    ) u_tracker (
        .CLK    (CLK),
        .reset  (reset),
        .en     (pe_en),
        .sample (sample)
    );

    assign capture = sample && (state_reg == FILL);
    assign drop    = sample && (state_reg == DRAIN);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg  <= FILL;
            wr_ptr_reg <= '0;
            rd_row_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (capture) begin
                        if (wr_ptr_reg == PTR_W'(N*N-1)) begin
                            state_reg  <= DRAIN;
                            wr_ptr_reg <= '0;
                            rd_row_reg <= '0;
                        end else begin
                            wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drop) begin
                        ovf_reg <= 1'b1;
                    end
                    if (out_ready) begin
                        if (rd_row_reg == ROW_W'(N-1)) begin
                            state_reg  <= FILL;
                            rd_row_reg <= '0;
                        end else begin
                            rd_row_reg <= rd_row_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    // Buffer content is don't-care after reset, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (capture) begin
            mem_reg[wr_ptr_reg] <= pe_c;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            logic [PTR_W-1:0] rd_idx;
            assign rd_idx = PTR_W'(rd_row_reg) * PTR_W'(N) + PTR_W'(gi);
            assign row_packed[(N-1-gi)*DATA_W +: DATA_W] = mem_reg[rd_idx];
        end
    endgenerate

    assign out_valid   = (state_reg == DRAIN);
    assign busy        = (state_reg == DRAIN);
    assign ovf         = ovf_reg;
    assign out_row_idx = rd_row_reg;
    assign out_last    = out_valid && (rd_row_reg == ROW_W'(N-1));
    assign out_row     = out_valid ? row_packed : '0;

`ifdef MC_COLLECT_DROPCNT_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_pe_result_collector.sv
// Scoreboard bench for pe_result_collector: expected rows are queued as data is
// driven and compared as the collector hands rows out.
module tb_pe_result_collector;
    import mc_pkg::*;

    localparam int DW = 32;
    localparam int NN = 4;

    logic           CLK;
    logic           reset;
    logic           pe_en;
    logic [DW-1:0]  pe_c;
    logic           out_valid;
    logic           out_ready;
    logic [NN*DW-1:0] out_row;
    logic [1:0]     out_row_idx;
    logic           out_last;
    logic           busy;
    logic           ovf;
`ifdef MC_COLLECT_DROPCNT_EN
    logic [7:0]     drop_cnt;
`endif

    typedef struct {
        logic [127:0] row;
        int           idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    pe_result_collector dut (
        .CLK         (CLK),
        .reset       (reset),
        .pe_en       (pe_en),
        .pe_c        (pe_c),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_last    (out_last),
        .busy        (busy),
        .ovf         (ovf)
`ifdef MC_COLLECT_DROPCNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Queue the first nrows rows of a 16-entry buffer image.
    task automatic push_rows(input logic [31:0] vals [16], input int nrows);
        logic [31:0] elems [4];
        exp_t e;
        for (int r = 0; r < nrows; r++) begin
            for (int k = 0; k < 4; k++) elems[k] = vals[r*4 + k];
            e.row = 128'(pack_row(elems));
            e.idx = r;
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input logic en, input logic [31:0] c);
        pe_en = en;
        pe_c  = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pe_en = 1'b0;
        out_ready = 1'b0;
        @(posedge CLK);
        #1;
        reset = 1'b0;
    endtask

    // Pushes the 16 values stored by a 3+16 cycle run of base+i, i=1..19.
    task automatic push_fill(input logic [31:0] base);
        logic [31:0] vals [16];
        for (int k = 0; k < 16; k++) vals[k] = base + 32'(k + 4);
        push_rows(vals, 4);
    endtask

    task automatic run_fill(input logic [31:0] base, input int ncyc);
        for (int i = 1; i <= ncyc; i++) cyc(1'b1, base + 32'(i));
    endtask

    always @(negedge CLK) begin
        if (!reset && out_valid && out_ready) begin
            $display("row accepted idx=%0d last=%0d data=%h", out_row_idx, out_last, out_row);
            if (exp_q.size() == 0) begin
                check_eq("row_unexpected", 128'(exp_q.size()), 128'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("row_data", out_row, e.row);
                check_eq("row_idx", 128'(out_row_idx), 128'(e.idx));
                check_eq("row_last", 128'(out_last), 128'(e.idx == 3));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] vals [16];
        logic [31:0] elems [4];

        reset = 1'b1;
        pe_en = 1'b0;
        pe_c = '0;
        out_ready = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_eq("rst_valid", 128'(out_valid), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_ovf", 128'(ovf), 128'd0);
        check_eq("rst_last", 128'(out_last), 128'd0);
        check_eq("rst_idx", 128'(out_row_idx), 128'd0);
        check_eq("rst_row", out_row, 128'd0);
`ifdef MC_COLLECT_DROPCNT_EN
        check_eq("rst_drop", 128'(drop_cnt), 128'd0);
`endif
        reset = 1'b0;

        // 1: 4+16 cycles of 1..20 with out_ready high; 4..19 are stored.
        out_ready = 1'b1;
        push_fill(32'd0);
        run_fill(32'd0, 20);
        idle(6);
        check_eq("t1_drained", 128'(exp_q.size()), 128'd0);
        check_eq("t1_ovf", 128'(ovf), 128'd1);
        check_eq("t1_busy", 128'(busy), 128'd0);

        // 2: negative data, consumer stalls 10 cycles after DRAIN entry.
        do_reset();
        push_fill(32'hFFFF_FFEC);
        run_fill(32'hFFFF_FFEC, 19);
        for (int k = 0; k < 4; k++) elems[k] = 32'hFFFF_FFF0 + 32'(k);
        for (int s = 0; s < 10; s++) begin
            cyc(1'b0, 32'h0);
            check_eq("t2_stall_valid", 128'(out_valid), 128'd1);
            check_eq("t2_stall_idx", 128'(out_row_idx), 128'd0);
            check_eq("t2_stall_row", out_row, 128'(pack_row(elems)));
        end
        out_ready = 1'b1;
        idle(3);
        check_eq("t2_last_hi", 128'(out_last), 128'd1);
        idle(1);
        check_eq("t2_valid_lo", 128'(out_valid), 128'd0);
        check_eq("t2_drained", 128'(exp_q.size()), 128'd0);
        check_eq("t2_ovf", 128'(ovf), 128'd0);

        // 3: pe_en drops after 8 samples; capture resumes into buf[8].
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) vals[k] = 32'd104 + 32'(k);
        for (int k = 0; k < 8; k++) vals[8 + k] = 32'd204 + 32'(k);
        push_rows(vals, 4);
        run_fill(32'd100, 11);
        cyc(1'b0, 32'd999);
        cyc(1'b0, 32'd998);
        run_fill(32'd200, 3);
        check_eq("t3_refill_busy", 128'(busy), 128'd0);
        for (int j = 4; j <= 11; j++) cyc(1'b1, 32'd200 + 32'(j));
        idle(6);
        check_eq("t3_drained", 128'(exp_q.size()), 128'd0);
        check_eq("t3_ovf", 128'(ovf), 128'd0);

        // 4: three samples arrive during DRAIN and are discarded.
        do_reset();
        push_fill(32'd300);
        run_fill(32'd300, 22);
        idle(1);
        check_eq("t4_ovf", 128'(ovf), 128'd1);
        check_eq("t4_busy", 128'(busy), 128'd1);
`ifdef MC_COLLECT_DROPCNT_EN
        check_eq("t4_drop_cnt", 128'(drop_cnt), 128'd3);
`endif
        out_ready = 1'b1;
        idle(4);
        check_eq("t4_drained", 128'(exp_q.size()), 128'd0);

        // 5: asynchronous reset while presenting row 2, then a clean refill.
        do_reset();
        for (int k = 0; k < 16; k++) vals[k] = 32'd404 + 32'(k);
        push_rows(vals, 2);
        run_fill(32'd400, 20);
        pe_en = 1'b0;
        out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
        check_eq("t5_idx2", 128'(out_row_idx), 128'd2);
        check_eq("t5_ovf_pre", 128'(ovf), 128'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_rst_valid", 128'(out_valid), 128'd0);
        check_eq("t5_rst_busy", 128'(busy), 128'd0);
        check_eq("t5_rst_ovf", 128'(ovf), 128'd0);
        check_eq("t5_rst_idx", 128'(out_row_idx), 128'd0);
        check_eq("t5_q_rows01", 128'(exp_q.size()), 128'd0);
        #2;
        reset = 1'b0;
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        push_fill(32'd500);
        run_fill(32'd500, 19);
        idle(6);
        check_eq("t5_drained", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
